// File: rtl/codma_desc_fetch.sv
// Fetches a two-word copy descriptor, validates it and presents it to the copy engine; type-2 descriptors link to ptr+32.
// Optional macro CODMA_LINK_CHAIN_EN lets linked descriptors chain further (up to 4 per start).
module codma_desc_fetch #(
  parameter int MEM_DEPTH = 32,
  parameter int MEM_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [31:0] task_pointer_i,
  output logic        busy_o,
  output logic        rd_req_o,
  output logic [31:0] rd_addr_o,
  input  logic        rd_gnt_i,
  input  logic        rd_valid_i,
  input  logic [63:0] rd_data_i,
  output logic        desc_valid_o,
  input  logic        desc_ready_i,
  output logic [31:0] desc_type_o,
  output logic [31:0] desc_src_o,
  output logic [31:0] desc_dst_o,
  output logic [31:0] desc_len_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);
  localparam logic [32:0] SPAN = 33'(MEM_DEPTH * MEM_WIDTH);
`ifdef CODMA_LINK_CHAIN_EN
  localparam logic [2:0] MAX_DESC = 3'd4;
`else
  localparam logic [2:0] MAX_DESC = 3'd2;
`endif

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, CHECK, PRESENT} state_t;
  state_t state, state_nxt;

  logic [31:0] ptr, link_ptr;
  logic [63:0] word0, word1;
  logic [2:0]  desc_cnt;
  logic        done_q, err_q;
  logic [1:0]  err_code_q, chk_code, link_code;
  logic [31:0] d_type, d_src, d_dst, d_len;
  logic        start_bad, accept, is_link;

  function automatic logic ptr_bad(input logic [31:0] p);
    return (p[2:0] != 3'd0) || (({1'b0, p} + 33'd16) > SPAN);
  endfunction

  assign d_type    = word0[31:0];
  assign d_src     = word0[63:32];
  assign d_dst     = word1[31:0];
  assign d_len     = word1[63:32];
  assign link_ptr  = ptr + 32'd32;
  assign start_bad = ptr_bad(task_pointer_i);
  assign accept    = (state == PRESENT) && desc_ready_i;
  assign is_link   = (d_type == 32'd2);
  assign link_code = ptr_bad(link_ptr) ? 2'd1 : ((desc_cnt == MAX_DESC) ? 2'd3 : 2'd0);

  always_comb begin
    chk_code = 2'd0;
    if (d_type > 32'd2) chk_code = 2'd2;
`ifndef CODMA_LINK_CHAIN_EN
    else if (is_link && (desc_cnt > 3'd1)) chk_code = 2'd2;
`endif
    else if ((d_len == 32'd0) ||
             ((d_type == 32'd0) ? (d_len[2:0] != 3'd0) : (d_len[4:0] != 5'd0)) ||
             (({1'b0, d_src} + {1'b0, d_len}) > SPAN) ||
             (({1'b0, d_dst} + {1'b0, d_len}) > SPAN))
      chk_code = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i && !start_bad) state_nxt = REQ0;
      REQ0:    if (rd_gnt_i) state_nxt = WAIT0;
      WAIT0:   if (rd_valid_i) state_nxt = REQ1;
      REQ1:    if (rd_gnt_i) state_nxt = WAIT1;
      WAIT1:   if (rd_valid_i) state_nxt = CHECK;
      CHECK:   state_nxt = (chk_code != 2'd0) ? IDLE : PRESENT;
      PRESENT: if (accept) state_nxt = (is_link && (link_code == 2'd0)) ? REQ0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state != IDLE);
    rd_req_o     = (state == REQ0) || (state == REQ1);
    rd_addr_o    = 32'd0;
    if (state == REQ0) rd_addr_o = ptr;
    if (state == REQ1) rd_addr_o = ptr + 32'd8;
    desc_valid_o = (state == PRESENT);
    desc_type_o  = desc_valid_o ? d_type : 32'd0;
    desc_src_o   = desc_valid_o ? d_src  : 32'd0;
    desc_dst_o   = desc_valid_o ? d_dst  : 32'd0;
    desc_len_o   = desc_valid_o ? d_len  : 32'd0;
    done_o       = done_q;
    err_o        = err_q;
    err_code_o   = err_code_q;
  end

  // Datapath and registered completion pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr        <= 32'd0;
      word0      <= 64'd0;
      word1      <= 64'd0;
      desc_cnt   <= 3'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          ptr        <= task_pointer_i;
          desc_cnt   <= 3'd1;
          err_q      <= start_bad;
          err_code_q <= start_bad ? 2'd1 : 2'd0;
        end
        WAIT0: if (rd_valid_i) word0 <= rd_data_i;
        WAIT1: if (rd_valid_i) word1 <= rd_data_i;
        CHECK: if (chk_code != 2'd0) begin
          err_q      <= 1'b1;
          err_code_q <= chk_code;
        end
        PRESENT: if (accept) begin
          if (!is_link) begin
            done_q <= 1'b1;
          end else if (link_code != 2'd0) begin
            err_q      <= 1'b1;
            err_code_q <= link_code;
          end else begin
            ptr      <= link_ptr;
            desc_cnt <= desc_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_codma_desc_fetch.sv
// Randomized and directed bench for codma_desc_fetch with a descriptor-walk reference model and a memory responder.
module tb_codma_desc_fetch;
  logic        clk = 1'b0, reset_n = 1'b0, start_i = 1'b0;
  logic [31:0] task_pointer_i = 32'd0;
  logic        busy_o, rd_req_o, rd_gnt_i = 1'b0, rd_valid_i = 1'b0;
  logic [31:0] rd_addr_o;
  logic [63:0] rd_data_i = 64'd0;
  logic        desc_valid_o, desc_ready_i = 1'b0;
  logic [31:0] desc_type_o, desc_src_o, desc_dst_o, desc_len_o;
  logic        done_o, err_o;
  logic [1:0]  err_code_o;

  always #5 clk = ~clk;

  codma_desc_fetch dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .task_pointer_i(task_pointer_i),
    .busy_o(busy_o), .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_gnt_i(rd_gnt_i),
    .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i), .desc_valid_o(desc_valid_o),
    .desc_ready_i(desc_ready_i), .desc_type_o(desc_type_o), .desc_src_o(desc_src_o),
    .desc_dst_o(desc_dst_o), .desc_len_o(desc_len_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o)
  );

`ifdef CODMA_LINK_CHAIN_EN
  localparam bit CHAIN = 1'b1;
  localparam int MAXD  = 4;
`else
  localparam bit CHAIN = 1'b0;
  localparam int MAXD  = 2;
`endif

  logic [63:0]  mem [32];
  int           n_cmp = 0, n_bad = 0;
  logic [127:0] exp_pres[$];
  logic [31:0]  exp_addr[$];
  bit           exp_done;
  logic [1:0]   exp_code;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walks the descriptor chain in memory using the rules directly.
  task automatic model(input logic [31:0] ptr);
    longint p = ptr;
    int n = 0;
    logic [31:0] ty, src, dst, len;
    exp_pres.delete(); exp_addr.delete();
    exp_done = 1'b0; exp_code = 2'd0;
    forever begin
      if ((p % 8) != 0 || p + 16 > 256) begin exp_code = 2'd1; return; end
      if (n == MAXD) begin exp_code = 2'd3; return; end
      exp_addr.push_back(32'(p));
      exp_addr.push_back(32'(p + 8));
      {src, ty}  = mem[int'(p / 8)];
      {len, dst} = mem[int'(p / 8) + 1];
      if (ty > 2 || (ty == 2 && n > 0 && !CHAIN)) begin exp_code = 2'd2; return; end
      if (len == 0 || (len % ((ty == 0) ? 8 : 32)) != 0 ||
          longint'(src) + longint'(len) > 256 || longint'(dst) + longint'(len) > 256) begin
        exp_code = 2'd3; return;
      end
      exp_pres.push_back({ty, src, dst, len});
      if (ty != 2) begin exp_done = 1'b1; return; end
      p = p + 32;
      n++;
    end
  endtask

  // gd/vd/rd: grant delay, valid delay, ready hold; negative = random plus junk stimulus.
  task automatic run(input logic [31:0] ptr, input int gd, input int vd, input int rd, output int first_v);
    logic [127:0] got_pres[$];
    logic [31:0]  got_addr[$];
    bit req_act = 0, val_pend = 0, pres_act = 0, fin = 0, got_done = 0;
    int gcnt = 0, vcnt = 0, hcnt = 0, cyc = 0;
    logic [31:0]  req_addr = 0, val_addr = 0;
    logic [127:0] first_f = 0, cur;
    model(ptr);
    first_v = -1;
    start_i = 1'b1; task_pointer_i = ptr;
    @(posedge clk); #1; start_i = 1'b0; cyc = 1;
    while (!fin && cyc < 400) begin
      rd_gnt_i = 0; rd_valid_i = 0; desc_ready_i = 0; rd_data_i = {$urandom, $urandom};
      cur = {desc_type_o, desc_src_o, desc_dst_o, desc_len_o};
      if (done_o || err_o) begin
        fin = 1; got_done = done_o;
      end else begin
        if (val_pend) begin
          if (vcnt == 0) begin
            rd_valid_i = 1; rd_data_i = mem[val_addr[7:3]]; val_pend = 0;
          end else vcnt--;
        end else if (gd < 0 && busy_o && $urandom_range(0, 7) == 0) rd_valid_i = 1;
        if (rd_req_o) begin
          if (!req_act) begin
            req_act = 1; req_addr = rd_addr_o;
            gcnt = (gd < 0) ? $urandom_range(0, 3) : gd;
          end else chk("addr_hold", rd_addr_o, req_addr);
          if (gcnt == 0) begin
            rd_gnt_i = 1; req_act = 0; got_addr.push_back(req_addr);
            val_pend = 1; val_addr = req_addr;
            vcnt = (vd < 0) ? $urandom_range(0, 3) : vd;
          end else gcnt--;
        end
        if (desc_valid_o) begin
          if (!pres_act) begin
            pres_act = 1; first_f = cur;
            hcnt = (rd < 0) ? $urandom_range(0, 3) : rd;
            if (first_v < 0) first_v = cyc;
          end else chk("desc_hold", cur, first_f);
          if (hcnt == 0) begin
            desc_ready_i = 1; got_pres.push_back(cur); pres_act = 0;
          end else hcnt--;
        end else chk("desc_zero", cur, 0);
        if (busy_o && gd < 0 && $urandom_range(0, 7) == 0) begin
          start_i = 1; task_pointer_i = $urandom_range(0, 255);
        end
      end
      @(posedge clk); #1; start_i = 0; cyc++;
    end
    chk("timeout", fin, 1);
    chk("outcome_done", got_done, exp_done);
    chk("err_code", err_code_o, exp_code);
    chk("pres_count", got_pres.size(), exp_pres.size());
    foreach (exp_pres[i]) if (i < got_pres.size()) chk("pres_fields", got_pres[i], exp_pres[i]);
    chk("rd_count", got_addr.size(), exp_addr.size());
    foreach (exp_addr[i]) if (i < got_addr.size()) chk("rd_addr", got_addr[i], exp_addr[i]);
    chk("idle_after", {busy_o, done_o, err_o, rd_req_o, desc_valid_o}, 0);
  endtask

  task automatic fill_random();
    logic [31:0] ty;
    int sel;
    int lens[7] = '{0, 8, 12, 16, 32, 64, 96};
    for (int i = 0; i < 32; i += 2) begin
      sel = $urandom_range(0, 9);
      ty = (sel < 3) ? 32'd0 : (sel < 5) ? 32'd1 : (sel < 9) ? 32'd2 : $urandom;
      mem[i]     = {32'($urandom_range(0, 31) * 8), ty};
      mem[i + 1] = {32'(lens[$urandom_range(0, 6)]), 32'($urandom_range(0, 31) * 8)};
    end
  endtask

  int fv;
  logic [31:0] rptr;

  initial begin
    foreach (mem[i]) mem[i] = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy_o, rd_req_o, rd_addr_o, desc_valid_o, done_o, err_o, err_code_o}, 0);
    chk("reset_desc", {desc_type_o, desc_src_o, desc_dst_o, desc_len_o}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    mem[0] = {32'h10, 32'h0}; mem[1] = {32'd16, 32'h80};
    run(32'h00, 0, 0, 0, fv);
    chk("first_valid_cycle", fv, 6);

    mem[8]  = {32'h00, 32'd2}; mem[9]  = {32'd32, 32'h20};
    mem[12] = {32'h30, 32'd0}; mem[13] = {32'd8, 32'h50};
    run(32'h40, 0, 0, 0, fv);
    run(32'h04, 0, 0, 0, fv);
    run(32'hF8, 0, 0, 0, fv);

    mem[2] = {32'hF0, 32'd1}; mem[3] = {32'd32, 32'h0};
    run(32'h10, 0, 0, 0, fv);
    mem[4] = {32'h0, 32'd3};  mem[5] = {32'd8, 32'h0};
    run(32'h20, 0, 0, 0, fv);
    mem[6] = {32'h0, 32'd0};  mem[7] = {32'd12, 32'h0};
    run(32'h30, 0, 0, 0, fv);

    run(32'h00, 3, 2, 5, fv);

    mem[16] = {32'h0, 32'd2}; mem[17] = {32'd32, 32'h0};
    mem[20] = {32'h0, 32'd2}; mem[21] = {32'd32, 32'h40};
    run(32'h80, 1, 1, 1, fv);

    // Reset while waiting for the second read's data
    start_i = 1; task_pointer_i = 32'h0;
    @(posedge clk); #1; start_i = 0; rd_gnt_i = 1;
    @(posedge clk); #1; rd_gnt_i = 0; rd_valid_i = 1; rd_data_i = mem[0];
    @(posedge clk); #1; rd_valid_i = 0; rd_gnt_i = 1;
    @(posedge clk); #1; rd_gnt_i = 0;
    chk("wait1_busy", {busy_o, rd_req_o}, 2'b10);
    reset_n = 0;
    @(posedge clk); #1; reset_n = 1; rd_valid_i = 1; rd_data_i = mem[1];
    chk("midreset_ctrl", {busy_o, rd_req_o, rd_addr_o, desc_valid_o, done_o, err_o, err_code_o}, 0);
    @(posedge clk); #1; rd_valid_i = 0;
    for (int i = 0; i < 5; i++) begin
      chk("midreset_quiet", {busy_o, rd_req_o, desc_valid_o, done_o, err_o, err_code_o}, 0);
      @(posedge clk); #1;
    end

    for (int t = 0; t < 60; t++) begin
      fill_random();
      rptr = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 15) * 16) : 32'($urandom_range(0, 255));
      run(rptr, -1, -1, -1, fv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
